mmio_bridge: RTL and testbench

//  Single-outstanding MMIO bridge between the core's data-side MMIO request port and the SoC peripherals.

---
 rtl/mmio_bridge_pkg.sv | 37 +++
 rtl/mmio_addr_decode.sv | 41 ++++
 rtl/mmio_bridge.sv | 173 +++++++++++++++++
 tb/tb_mmio_bridge.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bridge_pkg.sv
// Shared MMIO map for the bridge: window bases/sizes, access-size encodings,
// FSM state encoding, target ids, and the CLINT size/alignment rule.
package mmio_bridge_pkg;

  localparam logic [31:0] MAP_CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] MAP_CLINT_SIZE = 32'h0001_0000;
  localparam logic [31:0] MAP_UART_BASE  = 32'h1000_0000;
  localparam logic [31:0] MAP_UART_SIZE  = 32'h0000_0008;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] TGT_NONE  = 2'd0;
  localparam logic [1:0] TGT_CLINT = 2'd1;
  localparam logic [1:0] TGT_UART  = 2'd2;

  // CLINT registers are word/doubleword only and must be naturally aligned.
  function automatic logic clint_access_ok(input logic [2:0] size, input logic [2:0] low);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_W:  ok = (low[1:0] == 2'b00);
      SIZE_D:  ok = (low == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address decode: maps a request address and size onto a
// target id and reports whether the access must be faulted without
// touching any slave.
module mmio_addr_decode
  import mmio_bridge_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  CLINT_BASE = XLEN'(MAP_CLINT_BASE),
  parameter logic [XLEN-1:0]  UART_BASE  = XLEN'(MAP_UART_BASE)
) (
  input  logic [XLEN-1:0] addr,
  input  logic [2:0]      size,
  output logic [1:0]      tgt,
  output logic            fault
);

  logic [XLEN-1:0] clint_off;
  logic [XLEN-1:0] uart_off;
  logic            in_clint;
  logic            in_uart;

  // Offsets wrap below the base, so a single unsigned compare bounds each window.
  assign clint_off = addr - CLINT_BASE;
  assign uart_off  = addr - UART_BASE;
  assign in_clint  = (clint_off < XLEN'(MAP_CLINT_SIZE));
  assign in_uart   = (uart_off < XLEN'(MAP_UART_SIZE));

  // Select target and apply per-window size/alignment rules.
  always_comb begin
    tgt   = TGT_NONE;
    fault = 1'b1;
    if (in_clint) begin
      tgt   = TGT_CLINT;
      fault = !clint_access_ok(size, addr[2:0]);
    end else if (in_uart) begin
      tgt   = TGT_UART;
      fault = (size != SIZE_B);
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// Single-outstanding MMIO bridge: core MMIO request port -> CLINT / UART.
// Optional slave-ready watchdog is compiled in with `MMIO_TIMEOUT_EN.
// Master handshake: a request transfers on a cycle with m_req_valid &&
// m_req_ready; slave requests transfer on *_req_valid && *_req_ready; the
// response is a single-cycle m_rsp_valid pulse with no backpressure.
// dbg_state exposes the FSM state for observation.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] CLINT_BASE     = XLEN'(MAP_CLINT_BASE),
  parameter logic [XLEN-1:0] UART_BASE      = XLEN'(MAP_UART_BASE),
  parameter int              TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m_req_valid,
  output logic            m_req_ready,
  input  logic [XLEN-1:0] m_req_addr,
  input  logic [63:0]     m_req_wdata,
  input  logic            m_req_we,
  input  logic [2:0]      m_req_size,
  output logic            m_rsp_valid,
  output logic [63:0]     m_rsp_rdata,
  output logic            m_rsp_err,
  output logic            clint_req_valid,
  output logic            clint_req_we,
  output logic [15:0]     clint_req_addr,
  output logic [63:0]     clint_req_wdata,
  output logic [2:0]      clint_req_size,
  input  logic            clint_req_ready,
  input  logic [63:0]     clint_req_rdata,
  output logic            uart_req_valid,
  output logic            uart_req_we,
  output logic [2:0]      uart_req_addr,
  output logic [7:0]      uart_req_wdata,
  input  logic            uart_req_ready,
  input  logic [7:0]      uart_req_rdata,
  output logic [1:0]      dbg_state
);

  state_t      state, next_state;
  logic [15:0] addr_q;
  logic [63:0] wdata_q;
  logic        we_q;
  logic [2:0]  size_q;
  logic [1:0]  tgt_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic [1:0]  dec_tgt;
  logic        dec_fault;
  logic        accept;
  logic        slave_ready;
  logic        slave_hit;
  logic        timed_out;

  mmio_addr_decode #(
    .XLEN       (XLEN),
    .CLINT_BASE (CLINT_BASE),
    .UART_BASE  (UART_BASE)
  ) u_decode (
    .addr  (m_req_addr),
    .size  (m_req_size),
    .tgt   (dec_tgt),
    .fault (dec_fault)
  );

  assign accept      = m_req_valid && m_req_ready;
  assign slave_ready = (tgt_q == TGT_CLINT) ? clint_req_ready :
                       (tgt_q == TGT_UART)  ? uart_req_ready  : 1'b0;
  assign slave_hit   = (state == ISSUE) && slave_ready;

`ifdef MMIO_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES) + 1 > 8) ? $clog2(TIMEOUT_CYCLES) + 1 : 8;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt;

  // Count ISSUE cycles spent waiting on the slave; restart on each ISSUE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != ISSUE) begin
      wait_cnt <= '0;
    end else if (!slave_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A ready arriving on the final cycle still wins over the timeout.
  assign timed_out = (state == ISSUE) && !slave_ready && (wait_cnt == LIMIT);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timed_out      = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state      = state;
    m_req_ready     = 1'b0;
    m_rsp_valid     = 1'b0;
    clint_req_valid = 1'b0;
    uart_req_valid  = 1'b0;
    case (state)
      IDLE: begin
        m_req_ready = !reset;
        if (accept) next_state = dec_fault ? RESP : ISSUE;
      end
      ISSUE: begin
        clint_req_valid = (tgt_q == TGT_CLINT);
        uart_req_valid  = (tgt_q == TGT_UART);
        if (slave_ready || timed_out) next_state = RESP;
      end
      RESP: begin
        m_rsp_valid = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture on accept; response capture on fault, slave hit or timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      tgt_q   <= TGT_NONE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= m_req_addr[15:0];
        wdata_q <= m_req_wdata;
        we_q    <= m_req_we;
        size_q  <= m_req_size;
        tgt_q   <= dec_tgt;
        if (dec_fault) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (slave_hit) begin
        err_q <= 1'b0;
        if (we_q)                    rdata_q <= '0;
        else if (tgt_q == TGT_CLINT) rdata_q <= clint_req_rdata;
        else                         rdata_q <= {56'd0, uart_req_rdata};
      end else if (timed_out) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign m_rsp_rdata     = rdata_q;
  assign m_rsp_err       = err_q;
  assign clint_req_we    = we_q;
  assign clint_req_addr  = addr_q;
  assign clint_req_wdata = wdata_q;
  assign clint_req_size  = size_q;
  assign uart_req_we     = we_q;
  assign uart_req_addr   = addr_q[2:0];
  assign uart_req_wdata  = wdata_q[7:0];
  assign dbg_state       = state;

endmodule

// File: tb/tb_mmio_bridge.sv
// Testbench for mmio_bridge: directed cases plus randomized accesses checked
// against an address-map reference model and an expected-response queue.
module tb_mmio_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_req_valid;
  logic        m_req_ready;
  logic [31:0] m_req_addr;
  logic [63:0] m_req_wdata;
  logic        m_req_we;
  logic [2:0]  m_req_size;
  logic        m_rsp_valid;
  logic [63:0] m_rsp_rdata;
  logic        m_rsp_err;
  logic        clint_req_valid, clint_req_we, clint_req_ready;
  logic [15:0] clint_req_addr;
  logic [63:0] clint_req_wdata, clint_req_rdata;
  logic [2:0]  clint_req_size;
  logic        uart_req_valid, uart_req_we, uart_req_ready;
  logic [2:0]  uart_req_addr;
  logic [7:0]  uart_req_wdata, uart_req_rdata;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  // Clock.
  always #5 clk = ~clk;

  mmio_bridge #(
    .XLEN(32), .CLINT_BASE(32'h0200_0000), .UART_BASE(32'h1000_0000), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_we(m_req_we), .m_req_size(m_req_size),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
    .clint_req_valid(clint_req_valid), .clint_req_we(clint_req_we), .clint_req_addr(clint_req_addr),
    .clint_req_wdata(clint_req_wdata), .clint_req_size(clint_req_size),
    .clint_req_ready(clint_req_ready), .clint_req_rdata(clint_req_rdata),
    .uart_req_valid(uart_req_valid), .uart_req_we(uart_req_we), .uart_req_addr(uart_req_addr),
    .uart_req_wdata(uart_req_wdata), .uart_req_ready(uart_req_ready), .uart_req_rdata(uart_req_rdata),
    .dbg_state(dbg_state)
  );

  // Watchdog on total simulated time.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference address map: target 0=none 1=CLINT 2=UART, and fault flag.
  function automatic void model(input logic [31:0] a, input logic [2:0] sz,
                                output int tgt, output bit fault);
    tgt   = 0;
    fault = 1'b1;
    if (a >= 32'h0200_0000 && a <= 32'h0200_FFFF) begin
      tgt   = 1;
      fault = !((sz == 3'd2 && (a % 4) == 0) || (sz == 3'd3 && (a % 8) == 0));
    end else if (a >= 32'h1000_0000 && a <= 32'h1000_0007) begin
      tgt   = 2;
      fault = (sz != 3'd0);
    end
  endfunction

  // Drive one request; slave answers after dly wait cycles (dly<0: never).
  task automatic run_txn(input logic [31:0] a, input logic [63:0] wd, input logic w,
                         input logic [2:0] sz, input int dly, input logic [63:0] sd);
    int tgt;
    bit fault;
    int k, vcnt, hs, lat, exp_lat, exp_v, exp_hs;
    bit got;
    logic [63:0] exp_rd, rd, q_rd;
    logic exp_err, er;
    model(a, sz, tgt, fault);
    exp_err = fault || (dly < 0);
    if (exp_err || w)  exp_rd = 64'd0;
    else if (tgt == 1) exp_rd = sd;
    else               exp_rd = {56'd0, sd[7:0]};
    exp_q.push_back(exp_rd);
    exp_lat = fault ? 1 : ((dly < 0) ? TO + 1 : dly + 2);
    exp_v   = fault ? 0 : ((dly < 0) ? TO : dly + 1);
    exp_hs  = (fault || dly < 0) ? 0 : 1;
    clint_req_rdata = sd;
    uart_req_rdata  = sd[7:0];
    @(negedge clk);
    chk("req_ready_idle", m_req_ready, 1);
    m_req_valid = 1'b1; m_req_addr = a; m_req_wdata = wd; m_req_we = w; m_req_size = sz;
    @(posedge clk);
    @(negedge clk);
    m_req_valid = 1'b0;
    k = 1; vcnt = 0; hs = 0; got = 1'b0; lat = 0; rd = '0; er = 1'b0;
    while (!got && k <= 60) begin
      clint_req_ready = 1'b0;
      uart_req_ready  = 1'b0;
      if (clint_req_valid || uart_req_valid) begin
        vcnt++;
        chk("clint_sel", clint_req_valid, (tgt == 1));
        chk("uart_sel", uart_req_valid, (tgt == 2));
        if (tgt == 1) begin
          chk("clint_addr", clint_req_addr, a[15:0]);
          chk("clint_wdata", clint_req_wdata, wd);
          chk("clint_we", clint_req_we, w);
          chk("clint_size", clint_req_size, sz);
        end else begin
          chk("uart_addr", uart_req_addr, a[2:0]);
          chk("uart_wdata", uart_req_wdata, wd[7:0]);
          chk("uart_we", uart_req_we, w);
        end
        if (dly >= 0 && vcnt > dly) begin
          if (tgt == 1) clint_req_ready = 1'b1;
          else          uart_req_ready  = 1'b1;
          hs++;
        end
      end
      if (m_rsp_valid) begin
        got = 1'b1; lat = k; rd = m_rsp_rdata; er = m_rsp_err;
        chk("req_ready_rsp", m_req_ready, 0);
      end else begin
        chk("req_ready_busy", m_req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        k++;
      end
    end
    clint_req_ready = 1'b0;
    uart_req_ready  = 1'b0;
    chk("rsp_seen", got, 1);
    q_rd = exp_q.pop_front();
    if (got) begin
      chk("rsp_latency", lat, exp_lat);
      chk("rsp_rdata", rd, q_rd);
      chk("rsp_err", er, exp_err);
      chk("slave_valid_cycles", vcnt, exp_v);
      chk("slave_handshakes", hs, exp_hs);
      @(posedge clk);
      @(negedge clk);
      chk("rsp_pulse", m_rsp_valid, 0);
      chk("rsp_rdata_hold", m_rsp_rdata, q_rd);
      chk("rsp_err_hold", m_rsp_err, exp_err);
      chk("req_ready_back", m_req_ready, 1);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    int          cat;
    logic [31:0] unmapped [6];
    unmapped[0] = 32'h0201_0000; unmapped[1] = 32'h01FF_FFFC; unmapped[2] = 32'h1000_0008;
    unmapped[3] = 32'h0FFF_FFFF; unmapped[4] = 32'h3000_0000; unmapped[5] = 32'h0000_0000;

    // Reset.
    reset = 1'b1; m_req_valid = 1'b0; m_req_addr = '0; m_req_wdata = '0; m_req_we = 1'b0;
    m_req_size = '0; clint_req_ready = 1'b0; clint_req_rdata = '0;
    uart_req_ready = 1'b0; uart_req_rdata = '0;
    @(negedge clk);
    m_req_valid = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", m_req_ready, 0);
    chk("rst_rsp_valid", m_rsp_valid, 0);
    chk("rst_rsp_rdata", m_rsp_rdata, 0);
    chk("rst_rsp_err", m_rsp_err, 0);
    chk("rst_clint_valid", clint_req_valid, 0);
    chk("rst_uart_valid", uart_req_valid, 0);
    chk("rst_clint_addr", clint_req_addr, 0);
    chk("rst_clint_wdata", clint_req_wdata, 0);
    chk("rst_uart_wdata", uart_req_wdata, 0);
    m_req_valid = 1'b0;
    reset = 1'b0;

    // Directed cases.
    run_txn(32'h0200_BFF8, 64'd0, 1'b0, 3'd3, 0, 64'h1234);
    run_txn(32'h1000_0000, 64'h41, 1'b1, 3'd0, 0, 64'h99);
    run_txn(32'h3000_0000, 64'd0, 1'b0, 3'd2, 0, 64'h55);
    run_txn(32'h0200_0002, 64'd0, 1'b0, 3'd2, 0, 64'h55);
    run_txn(32'h1000_0000, 64'd0, 1'b0, 3'd2, 0, 64'h55);
    run_txn(32'h1000_0005, 64'd0, 1'b0, 3'd0, 5, 64'h60);
    run_txn(32'h0200_FFF8, 64'hA5A5_0000_1111_2222, 1'b1, 3'd3, 1, 64'h77);
    run_txn(32'h0200_0004, 64'd0, 1'b0, 3'd2, 2, 64'hCAFE_F00D_0BAD_BEEF);
    run_txn(32'h0201_0000, 64'd0, 1'b0, 3'd2, 0, 64'h1);
    run_txn(32'h0200_0004, 64'd0, 1'b0, 3'd3, 0, 64'h1);
    run_txn(32'h0200_0008, 64'd0, 1'b0, 3'd1, 0, 64'h1);
    run_txn(32'h1000_0007, 64'd0, 1'b0, 3'd0, 0, 64'hFFFF_FFFF_FFFF_FFEE);
    run_txn(32'h1000_0008, 64'd0, 1'b0, 3'd0, 0, 64'h1);

    // Randomized accesses.
    for (int i = 0; i < 40; i++) begin
      cat = $urandom_range(0, 3);
      sz  = 3'($urandom_range(0, 3));
      case (cat)
        0: a = 32'h0200_0000 + ($urandom_range(0, 32'hFFFF) & 32'hFFF8);
        1: a = 32'h0200_0000 + $urandom_range(0, 32'hFFFF);
        2: begin
          a = 32'h1000_0000 + $urandom_range(0, 7);
          if ($urandom_range(0, 3) != 0) sz = 3'd0;
        end
        default: a = ($urandom_range(0, 1) == 0) ? unmapped[$urandom_range(0, 5)] : $urandom;
      endcase
      run_txn(a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), sz,
              $urandom_range(0, 3), {$urandom, $urandom});
    end

    // Reset while a CLINT access is in ISSUE; the simultaneous ready is ignored.
    @(negedge clk);
    m_req_valid = 1'b1; m_req_addr = 32'h0200_4000; m_req_we = 1'b0; m_req_size = 3'd3;
    @(posedge clk);
    @(negedge clk);
    m_req_valid = 1'b0;
    chk("mid_rst_issue", clint_req_valid, 1);
    reset = 1'b1; clint_req_ready = 1'b1; clint_req_rdata = 64'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    clint_req_ready = 1'b0;
    chk("mid_rst_valid_drop", clint_req_valid, 0);
    chk("mid_rst_no_rsp", m_rsp_valid, 0);
    chk("mid_rst_ready", m_req_ready, 0);
    chk("mid_rst_rdata", m_rsp_rdata, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", m_rsp_valid, 0);
      chk("post_rst_idle_valid", clint_req_valid, 0);
    end
    run_txn(32'h0200_0010, 64'd0, 1'b0, 3'd2, 0, 64'h4242);

`ifdef MMIO_TIMEOUT_EN
    // CLINT never ready: watchdog ends the access with an error.
    run_txn(32'h0200_4000, 64'd0, 1'b0, 3'd3, -1, 64'h1);
    run_txn(32'h1000_0001, 64'd0, 1'b0, 3'd0, -1, 64'h1);
    // Ready on the last allowed cycle still completes normally.
    run_txn(32'h0200_4000, 64'd0, 1'b0, 3'd3, TO - 1, 64'h5151);
`endif

    chk("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
